// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a first-word-fall-through byte FIFO and the UART transmitter.
// master = transmitter (pops), slave = FIFO (presents head byte and empty flag).
interface fifo_uart_tx_if;
    logic       in_is_empty;
    logic [7:0] in_read_data;
    logic       out_read_ctrl;

    modport master (
        input  in_is_empty,
        input  in_read_data,
        output out_read_ctrl
    );

    modport slave (
        output in_is_empty,
        output in_read_data,
        input  out_read_ctrl
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a FWFT byte FIFO into UART frames: start, 8 data bits LSB first, optional even parity, stop.
// Frames chain back-to-back with no idle gap when the FIFO has data at the end of the stop bit.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line high, waiting for enable and a non-empty FIFO
// S_START  | start bit (low) for one bit time
// S_DATA   | 8 data bits, shift register bit 0 on the line
// S_PARITY | even-parity bit (only when PARITY_EN=1)
// S_STOP   | stop bit (high); may pop the next byte on its last cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_tx_enable,
    fifo_uart_tx_if.master fifo,
    output logic           out_tx,
    output logic           out_busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_tx;

    logic        w_baud_last;
    logic        w_take;

    assign w_baud_last = (r_baud == BAUD_LAST);

    // Gating with rst keeps the strobe quiet while the FSM is held in reset.
    assign w_take = ~rst & in_tx_enable & ~fifo.in_is_empty &
                    ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_last));

    assign fifo.out_read_ctrl = w_take;
    assign out_tx             = r_tx;
    assign out_busy           = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else if (w_take) begin
            r_state   <= S_START;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= fifo.in_read_data;
            r_parity  <= ^fifo.in_read_data;
            r_tx      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= 16'd0;
                    r_tx   <= 1'b1;
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud    <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= PARITY_EN ? S_PARITY : S_STOP;
                            r_tx    <= PARITY_EN ? r_parity : 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud  <= 16'd0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    // A pending pop was handled above; here the frame simply ends.
                    if (w_baud_last) begin
                        r_baud  <= 16'd0;
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= 16'd0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
